// File: rtl/led_pkg.sv
// Shared definitions for the MAX7219 chain driver: register map, state
// encodings and the power-up register sequence.
package led_pkg;

    // MAX7219 register addresses
    localparam logic [7:0] REG_NOOP      = 8'h00;
    localparam logic [7:0] REG_DIGIT0    = 8'h01;
    localparam logic [7:0] REG_DIGIT7    = 8'h08;
    localparam logic [7:0] REG_DECODE    = 8'h09;
    localparam logic [7:0] REG_INTENSITY = 8'h0A;
    localparam logic [7:0] REG_SCANLIMIT = 8'h0B;
    localparam logic [7:0] REG_SHUTDOWN  = 8'h0C;
    localparam logic [7:0] REG_TEST      = 8'h0F;

    // Index of the last frame of the power-up sequence (five frames)
    localparam logic [2:0] INIT_LAST = 3'd4;

    // Sequencer states
    typedef enum logic [1:0] {
        INIT  = 2'd0,
        SNAP  = 2'd1,
        ROW   = 2'd2,
        INTEN = 2'd3
    } led_state_t;

    // Serializer states
    typedef enum logic [1:0] {
        SH_IDLE  = 2'd0,
        SH_SHIFT = 2'd1,
        SH_GAP   = 2'd2
    } shift_state_t;

    // {address, value} of power-up frame idx; the same word goes to every chip
    function automatic logic [15:0] init_word(input logic [2:0] idx,
                                              input logic [3:0] inten);
        case (idx)
            3'd0:    init_word = {REG_SHUTDOWN, 8'h01};   // leave shutdown
            3'd1:    init_word = {REG_TEST, 8'h00};       // display test off
            3'd2:    init_word = {REG_DECODE, 8'h00};     // raw segment mode
            3'd3:    init_word = {REG_SCANLIMIT, 8'h07};  // scan all 8 rows
            default: init_word = {REG_INTENSITY, 4'h0, inten};
        endcase
    endfunction

endpackage

// File: rtl/led7219_shift.sv
// Serializer for one register frame to a MAX7219 chain. A frame is shifted
// MSB first with an idle-low serial clock, then CS is held high for a fixed
// gap so the chips latch. A new frame is accepted on the last gap cycle so
// back-to-back frames keep an exact period.
module led7219_shift
    import led_pkg::*;
#(
    parameter int NBITS   = 64,
    parameter int CLK_DIV = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [NBITS-1:0] frame,
    output logic             ready,
    output logic             done,
    output logic             leds_out,
    output logic             leds_cs,
    output logic             leds_clk
);

    localparam int DIVW = $clog2(2 * CLK_DIV);
    localparam int BITW = $clog2(NBITS);
    localparam logic [DIVW-1:0] HALF_LAST = DIVW'(CLK_DIV - 1);
    localparam logic [DIVW-1:0] GAP_LAST  = DIVW'(2 * CLK_DIV - 1);
    localparam logic [BITW-1:0] BIT_LAST  = BITW'(NBITS - 1);

    shift_state_t     state_reg, state_next;
    logic [NBITS-1:0] shift_reg;
    logic [DIVW-1:0]  div_reg;
    logic [BITW-1:0]  bit_reg;
    logic             phase_reg;
    logic             cs_reg;
    logic             sclk_reg;

    logic half_end, gap_end, bit_last, start;

    assign half_end = (div_reg == HALF_LAST);
    assign gap_end  = (div_reg == GAP_LAST);
    assign bit_last = (bit_reg == BIT_LAST);
    assign ready    = (state_reg == SH_IDLE) || ((state_reg == SH_GAP) && gap_end);
    assign start    = ready && load;

    // The shift register MSB is the data pin; it is cleared outside a frame
    assign leds_out = shift_reg[NBITS-1];
    assign leds_cs  = cs_reg;
    assign leds_clk = sclk_reg;

    // Next-state: idle -> shift -> gap -> (shift on new load | idle)
    always_comb begin
        state_next = state_reg;
        if (start) begin
            state_next = SH_SHIFT;
        end else begin
            case (state_reg)
                SH_SHIFT: if (half_end && phase_reg && bit_last) state_next = SH_GAP;
                SH_GAP:   if (gap_end) state_next = SH_IDLE;
                default:  state_next = state_reg;
            endcase
        end
    end

    // State register plus bit/half-period counters and the pin drivers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= SH_IDLE;
            shift_reg <= '0;
            div_reg   <= '0;
            bit_reg   <= '0;
            phase_reg <= 1'b0;
            cs_reg    <= 1'b1;
            sclk_reg  <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_reg <= state_next;
            done      <= 1'b0;
            if (start) begin
                shift_reg <= frame;
                div_reg   <= '0;
                bit_reg   <= '0;
                phase_reg <= 1'b0;
                cs_reg    <= 1'b0;
                sclk_reg  <= 1'b0;
            end else if (state_reg == SH_SHIFT) begin
                if (half_end) begin
                    div_reg   <= '0;
                    phase_reg <= ~phase_reg;
                    if (!phase_reg) begin
                        sclk_reg <= 1'b1;
                    end else begin
                        sclk_reg <= 1'b0;
                        if (bit_last) begin
                            // Last bit clocked: raise CS so the chips latch
                            shift_reg <= '0;
                            cs_reg    <= 1'b1;
                            done      <= 1'b1;
                        end else begin
                            shift_reg <= {shift_reg[NBITS-2:0], 1'b0};
                            bit_reg   <= bit_reg + BITW'(1);
                        end
                    end
                end else begin
                    div_reg <= div_reg + DIVW'(1);
                end
            end else if (state_reg == SH_GAP) begin
                div_reg <= gap_end ? '0 : div_reg + DIVW'(1);
            end
        end
    end

endmodule

// File: rtl/led7219_chain.sv
// Refresh sequencer for a daisy chain of MAX7219 8x8 LED drivers. Runs the
// power-up register sequence, then repeatedly snapshots the display data and
// sends it row by row. Intensity changes and re-init requests are held
// pending and serviced only between complete refreshes.
module led7219_chain
    import led_pkg::*;
#(
    parameter int         NCHIPS         = 4,
    parameter int         CLK_DIV        = 8,
    parameter logic [3:0] INTENSITY_INIT = 4'h4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [64*NCHIPS-1:0]  data,
    input  logic                  freeze,
    input  logic                  intensity_wr,
    input  logic [3:0]            intensity_val,
    input  logic                  reinit,
    output logic                  leds_out,
    output logic                  leds_cs,
    output logic                  leds_clk,
    output logic                  frame_done
);

    localparam int NBITS = 16 * NCHIPS;

    led_state_t           state_reg, state_next;
    logic                 sent_reg, sent_next;
    logic [2:0]           row_reg, row_next;
    logic [2:0]           idx_reg, idx_next;
    logic [64*NCHIPS-1:0] snap_reg;
    logic [3:0]           inten_cur_reg;
    logic [3:0]           inten_new_reg;
    logic                 pend_inten_reg;
    logic                 pend_reinit_reg;

    logic load, snap_en, inten_apply, clr_reinit, fdone_set;
    logic ready, done;
    logic [7:0] addr, common_val;
    logic [NBITS-1:0] frame;

    // Register address and the value shared by all chips for this step
    always_comb begin
        addr       = REG_NOOP;
        common_val = 8'h00;
        case (state_reg)
            INIT:    {addr, common_val} = init_word(idx_reg, inten_cur_reg);
            INTEN:   {addr, common_val} = {REG_INTENSITY, 4'h0, inten_new_reg};
            ROW:     addr = {5'b0, row_reg} + REG_DIGIT0;
            default: addr = REG_NOOP;
        endcase
    end

    // Chip 0 occupies the low word so it is shifted last, landing nearest the FPGA
    generate
        for (genvar gi = 0; gi < NCHIPS; gi++) begin : g_chip
            assign frame[16*gi +: 16] = (state_reg == ROW)
                ? {addr, snap_reg[64*gi + 8*int'(row_reg) +: 8]}
                : {addr, common_val};
        end
    endgenerate

    // Sequencer: one frame per step; a step advances when its frame is latched
    always_comb begin
        state_next  = state_reg;
        sent_next   = sent_reg;
        row_next    = row_reg;
        idx_next    = idx_reg;
        load        = 1'b0;
        snap_en     = 1'b0;
        inten_apply = 1'b0;
        clr_reinit  = 1'b0;
        fdone_set   = 1'b0;
        case (state_reg)
            INIT: begin
                if (!sent_reg) begin
                    load      = ready;
                    sent_next = ready;
                end else if (done) begin
                    sent_next = 1'b0;
                    if (idx_reg == INIT_LAST) begin
                        idx_next   = 3'd0;
                        state_next = SNAP;
                    end else begin
                        idx_next = idx_reg + 3'd1;
                    end
                end
            end
            SNAP: begin
                snap_en    = !freeze;
                row_next   = 3'd0;
                state_next = ROW;
            end
            ROW: begin
                if (!sent_reg) begin
                    load      = ready;
                    sent_next = ready;
                end else if (done) begin
                    sent_next = 1'b0;
                    if (row_reg == 3'd7) begin
                        fdone_set = 1'b1;
                        row_next  = 3'd0;
                        if (pend_inten_reg) begin
                            state_next = INTEN;
                        end else if (pend_reinit_reg) begin
                            state_next = INIT;
                            clr_reinit = 1'b1;
                        end else begin
                            state_next = SNAP;
                        end
                    end else begin
                        row_next = row_reg + 3'd1;
                    end
                end
            end
            INTEN: begin
                if (!sent_reg) begin
                    load        = ready;
                    sent_next   = ready;
                    inten_apply = ready;
                end else if (done) begin
                    sent_next = 1'b0;
                    if (pend_reinit_reg) begin
                        state_next = INIT;
                        clr_reinit = 1'b1;
                    end else begin
                        state_next = SNAP;
                    end
                end
            end
            default: state_next = INIT;
        endcase
    end

    // Sequencer state, snapshot and sticky request flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= INIT;
            sent_reg        <= 1'b0;
            row_reg         <= 3'd0;
            idx_reg         <= 3'd0;
            snap_reg        <= '0;
            inten_cur_reg   <= INTENSITY_INIT;
            inten_new_reg   <= INTENSITY_INIT;
            pend_inten_reg  <= 1'b0;
            pend_reinit_reg <= 1'b0;
            frame_done      <= 1'b0;
        end else begin
            state_reg  <= state_next;
            sent_reg   <= sent_next;
            row_reg    <= row_next;
            idx_reg    <= idx_next;
            frame_done <= fdone_set;
            if (snap_en) snap_reg <= data;
            // A fresh strobe wins over the clear so no request is lost
            if (intensity_wr) begin
                inten_new_reg  <= intensity_val;
                pend_inten_reg <= 1'b1;
            end else if (inten_apply) begin
                pend_inten_reg <= 1'b0;
            end
            if (inten_apply) inten_cur_reg <= inten_new_reg;
            if (reinit) begin
                pend_reinit_reg <= 1'b1;
            end else if (clr_reinit) begin
                pend_reinit_reg <= 1'b0;
            end
        end
    end

    led7219_shift #(
        .NBITS   (NBITS),
        .CLK_DIV (CLK_DIV)
    ) u_shift (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .frame    (frame),
        .ready    (ready),
        .done     (done),
        .leds_out (leds_out),
        .leds_cs  (leds_cs),
        .leds_clk (leds_clk)
    );

endmodule

// File: tb/tb_led7219_chain.sv
// Directed bench: a one-chip instance checks the power-up sequence and frame
// timing; a two-chip instance checks row data, freeze, intensity/reinit
// handling and asynchronous reset. Serial frames are decoded from the pins.
module tb_led7219_chain;

    typedef struct {
        logic [31:0] bits;
        int          nb;
        int          t0;
        int          t1;
    } frame_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    // One-chip instance
    logic        rst_n_a = 1'b0;
    logic [63:0] data_a  = '0;
    logic        freeze_a = 1'b0, iw_a = 1'b0, reinit_a = 1'b0;
    logic [3:0]  iv_a = 4'h0;
    logic        out_a, cs_a, lclk_a, fd_a;

    // Two-chip instance
    logic         rst_n_b = 1'b0;
    logic [127:0] data_b  = '0;
    logic         freeze_b = 1'b0, iw_b = 1'b0, reinit_b = 1'b0;
    logic [3:0]   iv_b = 4'h0;
    logic         out_b, cs_b, lclk_b, fd_b;

    led7219_chain #(.NCHIPS(1), .CLK_DIV(2), .INTENSITY_INIT(4'h4)) dut_a (
        .clk(clk), .rst_n(rst_n_a), .data(data_a), .freeze(freeze_a),
        .intensity_wr(iw_a), .intensity_val(iv_a), .reinit(reinit_a),
        .leds_out(out_a), .leds_cs(cs_a), .leds_clk(lclk_a), .frame_done(fd_a));

    led7219_chain #(.NCHIPS(2), .CLK_DIV(2), .INTENSITY_INIT(4'h4)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .data(data_b), .freeze(freeze_b),
        .intensity_wr(iw_b), .intensity_val(iv_b), .reinit(reinit_b),
        .leds_out(out_b), .leds_cs(cs_b), .leds_clk(lclk_b), .frame_done(fd_b));

    // Pin decoders: collect bits on serial-clock rise while CS low
    frame_t qa[$], qb[$];
    logic cs_pa = 1'b1, lc_pa = 1'b0, cs_pb = 1'b1, lc_pb = 1'b0;
    logic [31:0] sh_a = '0, sh_b = '0;
    int nb_a = 0, nb_b = 0, t0_a = 0, t0_b = 0, fd_cnt_b = 0;
    frame_t fa_tmp, fb_tmp;

    always @(negedge clk) begin
        if (!cs_a && cs_pa) begin sh_a = '0; nb_a = 0; t0_a = cyc; end
        if (!cs_a && lclk_a && !lc_pa) begin sh_a = {sh_a[30:0], out_a}; nb_a++; end
        if (cs_a && !cs_pa) begin
            fa_tmp.bits = sh_a; fa_tmp.nb = nb_a; fa_tmp.t0 = t0_a; fa_tmp.t1 = cyc;
            qa.push_back(fa_tmp);
        end
        cs_pa = cs_a; lc_pa = lclk_a;
    end

    always @(negedge clk) begin
        if (!cs_b && cs_pb) begin sh_b = '0; nb_b = 0; t0_b = cyc; end
        if (!cs_b && lclk_b && !lc_pb) begin sh_b = {sh_b[30:0], out_b}; nb_b++; end
        if (cs_b && !cs_pb) begin
            fb_tmp.bits = sh_b; fb_tmp.nb = nb_b; fb_tmp.t0 = t0_b; fb_tmp.t1 = cyc;
            qb.push_back(fb_tmp);
        end
        if (fd_b) fd_cnt_b++;
        cs_pb = cs_b; lc_pb = lclk_b;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic get_a(output frame_t f);
        int n = 0;
        while (qa.size() == 0 && n < 3000) begin @(negedge clk); n++; end
        checks++;
        assert (qa.size() != 0) else begin
            errors++;
            $error("FAIL timeout_a: got no frame expected frame within %0d cycles", n);
        end
        if (qa.size() != 0) f = qa.pop_front();
        else begin f.bits = '0; f.nb = 0; f.t0 = 0; f.t1 = 0; end
    endtask

    task automatic get_b(output frame_t f);
        int n = 0;
        while (qb.size() == 0 && n < 3000) begin @(negedge clk); n++; end
        checks++;
        assert (qb.size() != 0) else begin
            errors++;
            $error("FAIL timeout_b: got no frame expected frame within %0d cycles", n);
        end
        if (qb.size() != 0) f = qb.pop_front();
        else begin f.bits = '0; f.nb = 0; f.t0 = 0; f.t1 = 0; end
    endtask

    task automatic expect_b(input string tag, input logic [31:0] exp);
        frame_t f;
        get_b(f);
        chk(tag, f.bits, exp);
        chk({tag, "_nbits"}, f.nb, 32);
        $display("frame %s: %h (cycle %0d)", tag, f.bits, f.t0);
    endtask

    // Row r (0-based): chip 1 word first, then chip 0
    function automatic logic [31:0] row_exp(input int r, input logic [127:0] d);
        logic [7:0] a;
        a = 8'(r + 1);
        return {a, d[64 + 8*r +: 8], a, d[8*r +: 8]};
    endfunction

    task automatic rows(input string tag, input int from, input int to, input logic [127:0] d);
        for (int r = from; r <= to; r++)
            expect_b($sformatf("%s_row%0d", tag, r + 1), row_exp(r, d));
    endtask

    task automatic strobe(input logic [3:0] v, input logic iw, input logic ri);
        @(negedge clk);
        iv_b = v; iw_b = iw; reinit_b = ri;
        @(negedge clk);
        iw_b = 1'b0; reinit_b = 1'b0;
    endtask

    logic [127:0] orig, ones;
    logic [15:0]  init_a [5];
    logic [15:0]  init_w [5];
    frame_t f;
    int prev_t0;
    int n;

    initial begin
        orig = {64'h8877665544332211, 64'h0807060504030201};
        ones = '1;
        init_a = '{16'h0C01, 16'h0F00, 16'h0900, 16'h0B07, 16'h0A04};
        data_b = orig;
        repeat (3) @(negedge clk);

        // Outputs while in reset
        chk("reset_pins_a", {28'h0, cs_a, lclk_a, out_a, fd_a}, 32'h8);
        chk("reset_pins_b", {28'h0, cs_b, lclk_b, out_b, fd_b}, 32'h8);
        @(negedge clk);
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;

        // One chip: power-up words, CS-low time and frame period
        prev_t0 = 0;
        for (int i = 0; i < 5; i++) begin
            get_a(f);
            $display("frame a_init%0d: %h nbits=%0d cycle %0d", i, f.bits[15:0], f.nb, f.t0);
            chk($sformatf("a_init%0d", i), f.bits, {16'h0, init_a[i]});
            chk($sformatf("a_init%0d_nbits", i), f.nb, 16);
            chk($sformatf("a_init%0d_cslow", i), f.t1 - f.t0, 64);
            if (i > 0) chk($sformatf("a_init%0d_period", i), f.t0 - prev_t0, 68);
            prev_t0 = f.t0;
        end

        // Two chips: power-up sequence, no frame_done yet
        for (int i = 0; i < 5; i++)
            expect_b($sformatf("b_init%0d", i), {init_a[i], init_a[i]});
        chk("fd_after_init", fd_cnt_b, 0);

        // Refresh 1: change data and freeze mid-refresh; rows stay coherent
        expect_b("r1_row1", 32'h01110101);
        data_b   = ones;
        freeze_b = 1'b1;
        rows("r1", 1, 6, orig);
        expect_b("r1_row8", 32'h08880808);
        repeat (3) @(negedge clk);
        chk("fd_count_r1", fd_cnt_b, 1);

        // Refresh 2: frozen, previous snapshot shown again
        rows("r2", 0, 0, orig);
        freeze_b = 1'b0;
        rows("r2", 1, 7, orig);
        repeat (3) @(negedge clk);
        chk("fd_count_r2", fd_cnt_b, 2);

        // Refresh 3: new data; two intensity writes, only the latest is sent
        rows("r3", 0, 1, ones);
        strobe(4'h9, 1'b1, 1'b0);
        rows("r3", 2, 3, ones);
        strobe(4'hC, 1'b1, 1'b0);
        rows("r3", 4, 7, ones);
        expect_b("r3_inten", 32'h0A0C0A0C);

        // Refresh 4: reinit together with intensity write
        rows("r4", 0, 1, ones);
        strobe(4'h2, 1'b1, 1'b1);
        rows("r4", 2, 7, ones);
        expect_b("r4_inten", 32'h0A020A02);
        init_w = '{16'h0C01, 16'h0F00, 16'h0900, 16'h0B07, 16'h0A02};
        for (int i = 0; i < 5; i++)
            expect_b($sformatf("reinit%0d", i), {init_w[i], init_w[i]});
        expect_b("r5_row1", 32'h01FF01FF);
        chk("fd_count_r4", fd_cnt_b, 4);

        // Reset in the middle of a row frame
        n = 0;
        while (!(!cs_b && nb_b == 10) && n < 2000) begin @(negedge clk); n++; end
        chk("reached_bit10", nb_b, 10);
        rst_n_b = 1'b0;
        #1;
        chk("async_reset_pins", {29'h0, cs_b, lclk_b, out_b}, 32'h4);
        repeat (3) @(negedge clk);
        chk("reset_fd", {31'h0, fd_b}, 32'h0);
        qb.delete();
        rst_n_b = 1'b1;
        for (int i = 0; i < 5; i++)
            expect_b($sformatf("restart%0d", i), {init_a[i], init_a[i]});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
